decode_exe_pipe_stage: RTL

Parametrised decode→execute pipeline stage with valid/ready handshake, load-use hazard detection with configurable bubble insertion, branch flush, and a saturating stall counter. It sits between the decoder (controller, address decoder, immediate generator and register file read) and the execute stage. It replaces the fixed, always-enabled decode/execute register with one that can stall, flush and self-insert bubbles.

---
 rtl/decode_exe_pipe_stage_pkg.sv | 25 ++
 rtl/decode_exe_pipe_stage_load_use_detector.sv | 23 ++
 rtl/decode_exe_pipe_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/decode_exe_pipe_stage_pkg.sv
// Shared decode/execute definitions: the packed control bundle and bubble-count sizing.
package decode_exe_pipe_stage_pkg;

  typedef struct packed {
    logic [7:0] acc_imm;
    logic [4:0] alu_op;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [3:0] wr_en;
    logic       flag_upd;
    logic       mem_wr;
    logic       br_en;
  } ctrl_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_t);
  localparam int BUBBLE_CNT_W  = 2;

  // Hazard cycle counts as the first bubble, so the counter reloads with n-1 (n clamped to 1..3).
  function automatic logic [BUBBLE_CNT_W-1:0] bubble_reload(input int unsigned n);
    if (n <= 1) return '0;
    if (n >= 3) return BUBBLE_CNT_W'(2);
    return BUBBLE_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/decode_exe_pipe_stage_load_use_detector.sv
// Raw load-use match between incoming sources and the load held in the stage.
// Purely combinational; qualification by valid/bubble/flush happens in the top.
module load_use_detector #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  src1_used_i,
  input  logic                  src2_used_i,
  input  logic [ADDR_WIDTH-1:0] src1_addr_i,
  input  logic [ADDR_WIDTH-1:0] src2_addr_i,
  input  logic [ADDR_WIDTH-1:0] dest_addr_i,
  input  logic                  reg_wr_i,
  input  logic                  mem_read_i,
  output logic                  match_o
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = src1_used_i && (src1_addr_i == dest_addr_i);
  assign src2_hit = src2_used_i && (src2_addr_i == dest_addr_i);
  assign match_o  = mem_read_i && reg_wr_i && (src1_hit || src2_hit);

endmodule

// File: rtl/decode_exe_pipe_stage.sv
// Decode->execute register with valid/ready, load-use bubbles, flush and a saturating stall counter.
// One cycle latency; in_ready_o drops on downstream backpressure, a hazard or a pending bubble.
module decode_exe_pipe_stage
  import decode_exe_pipe_stage_pkg::*;
#(
  parameter int WORD             = 32,
  parameter int ADDR_WIDTH       = 4,
  parameter int CTRL_WIDTH       = CTRL_BUNDLE_W,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [CTRL_WIDTH-1:0]      ctrl_i,
  input  logic                       mem_read_i,
  input  logic                       reg_wr_i,
  input  logic                       src1_used_i,
  input  logic                       src2_used_i,
  input  logic [ADDR_WIDTH-1:0]      src1_addr_i,
  input  logic [ADDR_WIDTH-1:0]      src2_addr_i,
  input  logic [ADDR_WIDTH-1:0]      dest_addr_i,
  input  logic [WORD-1:0]            immediate_i,
  input  logic [WORD-1:0]            reg1_data_i,
  input  logic [WORD-1:0]            reg2_data_i,
  input  logic [WORD-1:0]            pc_i,
  input  logic                       flush_i,
  input  logic                       clr_stats_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CTRL_WIDTH-1:0]      ctrl_o,
  output logic                       mem_read_o,
  output logic                       reg_wr_o,
  output logic [ADDR_WIDTH-1:0]      src1_addr_o,
  output logic [ADDR_WIDTH-1:0]      src2_addr_o,
  output logic [ADDR_WIDTH-1:0]      dest_addr_o,
  output logic [WORD-1:0]            immediate_o,
  output logic [WORD-1:0]            reg1_data_o,
  output logic [WORD-1:0]            reg2_data_o,
  output logic [WORD-1:0]            pc_o,
  output logic                       hazard_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

  localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_RELOAD = bubble_reload(LOAD_USE_BUBBLES);

  logic                       out_valid_q, out_valid_d;
  logic [BUBBLE_CNT_W-1:0]    bubble_q, bubble_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic                  mem_read_q, reg_wr_q;
  logic [ADDR_WIDTH-1:0] src1_addr_q, src2_addr_q, dest_addr_q;
  logic [WORD-1:0]       imm_q, reg1_q, reg2_q, pc_q;

  logic raw_match;
  logic bubble_busy;
  logic accept;

  load_use_detector #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_load_use_detector (
    .src1_used_i (src1_used_i),
    .src2_used_i (src2_used_i),
    .src1_addr_i (src1_addr_i),
    .src2_addr_i (src2_addr_i),
    .dest_addr_i (dest_addr_q),
    .reg_wr_i    (reg_wr_q),
    .mem_read_i  (mem_read_q),
    .match_o     (raw_match)
  );

  assign bubble_busy = (bubble_q != '0);
  assign hazard_o    = in_valid_i && out_valid_q && raw_match && !bubble_busy && !flush_i;
  assign in_ready_o  = (!out_valid_q || out_ready_i) && !hazard_o && !bubble_busy;
  assign accept      = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    out_valid_d = out_valid_q;
    bubble_d    = bubble_q;
    stall_d     = stall_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      bubble_d    = '0;
    end else begin
      if (accept)           out_valid_d = 1'b1;
      else if (out_ready_i) out_valid_d = 1'b0;
      // A hazard that can drain starts the bubble; one that cannot just re-evaluates.
      if (hazard_o && out_ready_i) bubble_d = BUBBLE_RELOAD;
      else if (bubble_busy)        bubble_d = bubble_q - BUBBLE_CNT_W'(1);
    end
    if (clr_stats_i)
      stall_d = '0;
    else if (in_valid_i && !in_ready_o && !flush_i && !(&stall_q))
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid_q <= 1'b0;
      bubble_q    <= '0;
      stall_q     <= '0;
      ctrl_q      <= '0;
      mem_read_q  <= 1'b0;
      reg_wr_q    <= 1'b0;
      src1_addr_q <= '0;
      src2_addr_q <= '0;
      dest_addr_q <= '0;
      imm_q       <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bubble_q    <= bubble_d;
      stall_q     <= stall_d;
      if (accept) begin
        ctrl_q      <= ctrl_i;
        mem_read_q  <= mem_read_i;
        reg_wr_q    <= reg_wr_i;
        src1_addr_q <= src1_addr_i;
        src2_addr_q <= src2_addr_i;
        dest_addr_q <= dest_addr_i;
        imm_q       <= immediate_i;
        reg1_q      <= reg1_data_i;
        reg2_q      <= reg2_data_i;
        pc_q        <= pc_i;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign ctrl_o        = ctrl_q;
  assign mem_read_o    = mem_read_q;
  assign reg_wr_o      = reg_wr_q;
  assign src1_addr_o   = src1_addr_q;
  assign src2_addr_o   = src2_addr_q;
  assign dest_addr_o   = dest_addr_q;
  assign immediate_o   = imm_q;
  assign reg1_data_o   = reg1_q;
  assign reg2_data_o   = reg2_q;
  assign pc_o          = pc_q;
  assign stall_count_o = stall_q;

endmodule
